// File: rtl/nnrv_regfile_mp_pkg.sv
// Shared defaults and FSM encoding for the nnrv multi-port register file.
package nnrv_regfile_mp_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_REG_NUM = 32;

  typedef enum logic {
    NNRV_RF_CLEAR = 1'b0,
    NNRV_RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/nnrv_regfile_wsel.sv
// Write-port priority resolver for one address: highest-indexed committing port wins.
// Combinational; drops out-of-range addresses and, with ZERO_REG, address 0.
module nnrv_regfile_wsel #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int AW       = 5,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [AW-1:0]       addr,
  output logic                hit,
  output logic [XLEN-1:0]     data
);

  localparam logic [AW:0] REG_LIM = (AW+1)'(REG_NUM);

  logic addr_ok;

  assign addr_ok = ({1'b0, addr} < REG_LIM) && !((ZERO_REG != 0) && (addr == '0));

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Ascending scan so a later (higher) port overrides an earlier match.
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && addr_ok && (wr_addr[w*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wr_data[w*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/nnrv_regfile_mp.sv
// Multi-port register file with registered reads, write-first bypass and post-reset clear.
// Read latency 1 cycle; o_ready low while the clear sequencer runs (writes dropped, reads 0).
module nnrv_regfile_mp
  import nnrv_regfile_mp_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int REG_NUM  = DEF_REG_NUM,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic [NRD-1:0]      i_rd_en,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  input  logic [NWR-1:0]      i_wr_en,
  input  logic [NWR*AW-1:0]   i_wr_addr,
  input  logic [NWR*XLEN-1:0] i_wr_data,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic                o_ready
);

  localparam logic [AW:0]   REG_LIM  = (AW+1)'(REG_NUM);
  localparam logic [AW-1:0] LAST_IDX = AW'(REG_NUM - 1);

  rf_state_t            state_q, state_d;
  logic [AW-1:0]        clr_idx_q, clr_idx_d;
  logic                 run;
  logic [NWR-1:0]       wr_commit;
  logic [XLEN-1:0]      mem [REG_NUM];
  logic [REG_NUM-1:0]   ent_hit;
  logic [XLEN-1:0]      ent_val [REG_NUM];
  logic [NRD-1:0]       byp_hit;
  logic [NRD*XLEN-1:0]  byp_data;
  logic [NRD*XLEN-1:0]  rd_next;
  logic [NRD*XLEN-1:0]  rd_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= NNRV_RF_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      NNRV_RF_CLEAR: begin
        if (clr_idx_q == LAST_IDX) begin
          state_d   = NNRV_RF_RUN;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      NNRV_RF_RUN: begin
        if (i_clr) begin
          state_d   = NNRV_RF_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = NNRV_RF_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  assign run     = (state_q == NNRV_RF_RUN);
  assign o_ready = run;
  // The edge that accepts a clear request performs no writes, so bypass must not see them either.
  assign wr_commit = i_wr_en & {NWR{run & ~i_clr}};

  for (genvar r = 0; r < REG_NUM; r++) begin : g_ent
    nnrv_regfile_wsel #(
      .XLEN(XLEN), .REG_NUM(REG_NUM), .AW(AW), .NWR(NWR), .ZERO_REG(ZERO_REG)
    ) u_wsel (
      .wr_en   (wr_commit),
      .wr_addr (i_wr_addr),
      .wr_data (i_wr_data),
      .addr    (AW'(r)),
      .hit     (ent_hit[r]),
      .data    (ent_val[r])
    );
  end

  for (genvar p = 0; p < NRD; p++) begin : g_byp
    nnrv_regfile_wsel #(
      .XLEN(XLEN), .REG_NUM(REG_NUM), .AW(AW), .NWR(NWR), .ZERO_REG(ZERO_REG)
    ) u_wsel (
      .wr_en   (wr_commit),
      .wr_addr (i_wr_addr),
      .wr_data (i_wr_data),
      .addr    (i_rd_addr[p*AW +: AW]),
      .hit     (byp_hit[p]),
      .data    (byp_data[p*XLEN +: XLEN])
    );
  end

  // Storage has no reset; the clear sequencer is what initialises it.
  always_ff @(posedge i_clk) begin
    if (!run) begin
      mem[clr_idx_q] <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (ent_hit[r]) mem[r] <= ent_val[r];
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int p = 0; p < NRD; p++) begin
      if (i_rd_en[p] && ({1'b0, i_rd_addr[p*AW +: AW]} < REG_LIM) &&
          !((ZERO_REG != 0) && (i_rd_addr[p*AW +: AW] == '0))) begin
        if (byp_hit[p]) rd_next[p*XLEN +: XLEN] = byp_data[p*XLEN +: XLEN];
        else            rd_next[p*XLEN +: XLEN] = mem[i_rd_addr[p*AW +: AW]];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  rd_q <= '0;
    else if (!run) rd_q <= '0;
    else           rd_q <= rd_next;
  end

  assign o_rd_data = rd_q;

endmodule

// File: tb/tb_nnrv_regfile_mp.sv
// Directed bench: a 32-entry 2R/2W file and a 24-entry 1R/1W file on a shared clock and reset.
module tb_nnrv_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        clr = 1'b0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [63:0] rd_data;
  logic        ready;

  logic        s_clr = 1'b0;
  logic        s_rd_en = 1'b0;
  logic [4:0]  s_rd_addr = '0;
  logic        s_wr_en = 1'b0;
  logic [4:0]  s_wr_addr = '0;
  logic [31:0] s_wr_data = '0;
  logic [31:0] s_rd_data;
  logic        s_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nnrv_regfile_mp #(
    .XLEN(32), .REG_NUM(32), .AW(5), .NRD(2), .NWR(2), .ZERO_REG(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_rd_data(rd_data), .o_ready(ready)
  );

  nnrv_regfile_mp #(
    .XLEN(32), .REG_NUM(24), .AW(5), .NRD(1), .NWR(1), .ZERO_REG(1)
  ) dut24 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(s_clr),
    .i_rd_en(s_rd_en), .i_rd_addr(s_rd_addr),
    .i_wr_en(s_wr_en), .i_wr_addr(s_wr_addr), .i_wr_data(s_wr_data),
    .o_rd_data(s_rd_data), .o_ready(s_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    clr = 1'b0; rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rd0", rd_data[31:0], 32'h0);
    chk("rst_rd1", rd_data[63:32], 32'h0);
    tick();
    rst_n = 1'b1;

    // Clear sequence after reset release: 31 edges not ready, ready after the 32nd
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("clr_rel_busy", 32'(ready), 32'd0);
    end
    tick();
    chk("clr_rel_ready", 32'(ready), 32'd1);
    chk("s_ready", 32'(s_ready), 32'd1);

    // Every entry reads zero after the clear
    for (int a = 0; a < 32; a += 2) begin
      rd_en = 2'b11;
      rd_addr = {5'(a + 1), 5'(a)};
      tick();
      chk("init_rd0", rd_data[31:0], 32'h0);
      chk("init_rd1", rd_data[63:32], 32'h0);
    end
    idle();

    // Write x5, read on both ports next cycle
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    tick();
    idle();
    rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    tick();
    chk("x5_p0", rd_data[31:0], 32'hDEADBEEF);
    chk("x5_p1", rd_data[63:32], 32'hDEADBEEF);

    // Bypass on x7 while port 1 reads stored x5
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h12345678};
    rd_en = 2'b11; rd_addr = {5'd5, 5'd7};
    tick();
    chk("byp_x7", rd_data[31:0], 32'h12345678);
    chk("x5_again", rd_data[63:32], 32'hDEADBEEF);
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    tick();
    chk("x7_stored", rd_data[31:0], 32'h12345678);

    // x0 hardwired: same-cycle and later reads both zero
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF};
    rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    tick();
    chk("x0_byp", rd_data[31:0], 32'h0);
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    tick();
    chk("x0_rd", rd_data[31:0], 32'h0);

    // Two write ports on x3: port 1 wins
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h2, 32'h1};
    tick();
    idle();
    rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
    tick();
    chk("x3_prio", rd_data[63:32], 32'h2);
    chk("p0_dis", rd_data[31:0], 32'h0);

    // Two ports on x4 with same-cycle read: bypass returns the port 1 value
    wr_en = 2'b11; wr_addr = {5'd4, 5'd4}; wr_data = {32'hB, 32'hA};
    rd_en = 2'b11; rd_addr = {5'd4, 5'd4};
    tick();
    chk("x4_byp0", rd_data[31:0], 32'hB);
    chk("x4_byp1", rd_data[63:32], 32'hB);
    idle();

    // Disabled read port returns zero even for a nonzero entry
    rd_en = 2'b10; rd_addr = {5'd5, 5'd5};
    tick();
    chk("rd_dis", rd_data[31:0], 32'h0);
    chk("rd_en1", rd_data[63:32], 32'hDEADBEEF);
    idle();

    // 24-entry file: address 30 out of range, 23 is the last valid entry
    s_wr_en = 1'b1; s_wr_addr = 5'd30; s_wr_data = 32'hCAFEF00D;
    s_rd_en = 1'b1; s_rd_addr = 5'd30;
    tick();
    chk("s_oor_byp", s_rd_data, 32'h0);
    s_wr_en = 1'b0;
    tick();
    chk("s_oor_rd", s_rd_data, 32'h0);
    s_wr_en = 1'b1; s_wr_addr = 5'd23; s_wr_data = 32'h00000077;
    s_rd_en = 1'b0;
    tick();
    s_wr_en = 1'b0; s_rd_en = 1'b1; s_rd_addr = 5'd23;
    tick();
    chk("s_x23", s_rd_data, 32'h00000077);
    s_rd_en = 1'b0;

    // x9 written, then a clear pulse; writes to x1 held for the whole clear
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hA5A5A5A5};
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    tick();
    chk("x9_pre", rd_data[31:0], 32'hA5A5A5A5);
    idle();
    clr = 1'b1;
    tick();
    chk("clr_drop", 32'(ready), 32'd0);
    clr = 1'b0;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd1}; wr_data = {32'h0, 32'h55555555};
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("clr_busy", 32'(ready), 32'd0);
    end
    chk("clr_rd_zero", rd_data[31:0], 32'h0);
    tick();
    chk("clr_ready", 32'(ready), 32'd1);
    idle();
    rd_en = 2'b11; rd_addr = {5'd1, 5'd9};
    tick();
    chk("x9_cleared", rd_data[31:0], 32'h0);
    chk("x1_dropped", rd_data[63:32], 32'h0);
    idle();

    // Reset asserted mid-clear restarts the full sequence
    wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'h0, 32'h66666666};
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd6};
    tick();
    chk("x6_pre", rd_data[31:0], 32'h66666666);
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_rd", rd_data[31:0], 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("rst2_busy", 32'(ready), 32'd0);
    end
    tick();
    chk("rst2_ready", 32'(ready), 32'd1);
    rd_en = 2'b01; rd_addr = {5'd0, 5'd6};
    tick();
    chk("x6_cleared", rd_data[31:0], 32'h0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
